// File: rtl/layer2_window_gen_if.sv
// Stream bundle for layer2_window_gen: pooled pixels in, padded 3x3 windows out.
interface layer2_window_gen_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CH         = 8,
    parameter int WIDTH      = 56
);
    localparam int PIX_W = DATA_WIDTH * CH;
    localparam int CW    = $clog2(WIDTH);

    logic [PIX_W-1:0]   i_data;
    logic               valid_in;
    logic               in_ready;
    logic [9*PIX_W-1:0] o_window;
    logic               valid_out;
    logic [CW-1:0]      o_row;
    logic [CW-1:0]      o_col;
    logic               frame_done;

    modport master (
        output i_data, valid_in,
        input  in_ready, o_window, valid_out, o_row, o_col, frame_done
    );

    modport slave (
        input  i_data, valid_in,
        output in_ready, o_window, valid_out, o_row, o_col, frame_done
    );
endinterface

// File: rtl/layer2_window_gen.sv
// Streaming same-padded 3x3 window generator: two line buffers plus a shifting
// 3x3 register window, with a tail cycle per row and a flush of the last row.
module layer2_window_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int CH         = 8,
    parameter int WIDTH      = 56
) (
    input  logic               clk,
    input  logic               rst,
    layer2_window_gen_if.slave bus
);
    localparam int PIX_W = DATA_WIDTH * CH;
    localparam int CW    = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {RUN, TAIL, FLUSH} state_e;
    typedef logic [PIX_W-1:0] pix_t;
    // One window column, index = tap row dr (0 = top).
    typedef logic [2:0][PIX_W-1:0] col_t;

    state_e              state_q, state_d;
    logic [CW-1:0]       row_q, row_d, col_q, col_d;
    logic [CW-1:0]       tail_row_q, tail_row_d;
    logic                tail_last_q, tail_last_d;
    logic                in_ready, accept;

    pix_t                lb1_q [WIDTH];
    pix_t                lb2_q [WIDTH];
    col_t                win_q [3];
    col_t                new_col;
    col_t                src [3];
    logic [CW-1:0]       idx_l, idx_r;
    logic                pad_t, pad_b, pad_l, pad_r;

    logic [8:0][PIX_W-1:0] o_window_q, o_window_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [CW-1:0]         orow_q, orow_d, ocol_q, ocol_d;

    assign accept  = bus.valid_in && in_ready;
    assign new_col = {bus.i_data, lb1_q[col_q], lb2_q[col_q]};
    assign idx_l   = (col_q == '0)   ? '0    : col_q - ONE;
    assign idx_r   = (col_q == LAST) ? col_q : col_q + ONE;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            row_q       <= '0;
            col_q       <= '0;
            tail_row_q  <= '0;
            tail_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            tail_row_q  <= tail_row_d;
            tail_last_q <= tail_last_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (accept && col_q == LAST && row_q != '0) state_d = TAIL;
            TAIL:    state_d = tail_last_q ? FLUSH : RUN;
            FLUSH:   if (col_q == LAST) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        in_ready = (state_q == RUN) || (state_q == TAIL && !tail_last_q);
    end

    // Raster counters; during FLUSH the column counter walks the last row.
    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        tail_row_d  = tail_row_q;
        tail_last_d = tail_last_q;
        if (accept) begin
            if (col_q == LAST) begin
                col_d       = '0;
                row_d       = (row_q == LAST) ? '0 : row_q + ONE;
                tail_row_d  = row_q - ONE;
                tail_last_d = (row_q == LAST);
            end else begin
                col_d = col_q + ONE;
            end
        end else if (state_q == FLUSH) begin
            col_d = (col_q == LAST) ? '0 : col_q + ONE;
        end
    end

    // Emission mux: pick three source columns and the padding edges, then
    // force padded taps to zero so stale buffer data never escapes.
    always_comb begin
        src[0]  = win_q[1];
        src[1]  = win_q[2];
        src[2]  = new_col;
        pad_t   = 1'b0;
        pad_b   = 1'b0;
        pad_l   = 1'b0;
        pad_r   = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        unique case (state_q)
            RUN: begin
                valid_d = accept && row_q != '0 && col_q != '0;
                orow_d  = row_q - ONE;
                ocol_d  = col_q - ONE;
                pad_t   = (row_q == ONE);
                pad_l   = (col_q == ONE);
            end
            TAIL: begin
                valid_d = 1'b1;
                orow_d  = tail_row_q;
                ocol_d  = LAST;
                pad_t   = (tail_row_q == '0);
                pad_r   = 1'b1;
            end
            FLUSH: begin
                src[0]  = {pix_t'(0), lb1_q[idx_l], lb2_q[idx_l]};
                src[1]  = {pix_t'(0), lb1_q[col_q], lb2_q[col_q]};
                src[2]  = {pix_t'(0), lb1_q[idx_r], lb2_q[idx_r]};
                valid_d = 1'b1;
                done_d  = (col_q == LAST);
                orow_d  = LAST;
                ocol_d  = col_q;
                pad_b   = 1'b1;
                pad_l   = (col_q == '0);
                pad_r   = (col_q == LAST);
            end
            default: ;
        endcase
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                o_window_d[3*dr+dc] = ((dr == 0 && pad_t) || (dr == 2 && pad_b) ||
                                       (dc == 0 && pad_l) || (dc == 2 && pad_r))
                                      ? pix_t'(0) : src[dc][dr];
            end
        end
    end

    // NOTE: line buffers and the shift window carry no reset; any stale entry
    // is only ever read into a tap that the padding logic forces to zero.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= bus.i_data;
            win_q[0]     <= win_q[1];
            win_q[1]     <= win_q[2];
            win_q[2]     <= new_col;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_window_q <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            orow_q     <= '0;
            ocol_q     <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            if (valid_d) begin
                o_window_q <= o_window_d;
                orow_q     <= orow_d;
                ocol_q     <= ocol_d;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.o_window   = o_window_q;
    assign bus.valid_out  = valid_q;
    assign bus.o_row      = orow_q;
    assign bus.o_col      = ocol_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_layer2_window_gen.sv
// Directed + randomized bench for layer2_window_gen on a 4x4 frame, checked
// against a direct same-padded 3x3 window model of each frame image.
module tb_layer2_window_gen;
    localparam int DW    = 8;
    localparam int CH    = 1;
    localparam int W     = 4;
    localparam int PIX_W = DW * CH;
    localparam int WIN_W = 9 * PIX_W;

    typedef logic [WIN_W-1:0] win_t;
    typedef struct {
        int   row;
        int   col;
        win_t win;
        bit   fd;
        int   cyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    layer2_window_gen_if #(.DATA_WIDTH(DW), .CH(CH), .WIDTH(W)) bus ();
    layer2_window_gen #(.DATA_WIDTH(DW), .CH(CH), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    rec_t got[$];
    int   img [2][W*W];
    int   vectors = 0;
    int   miscompares = 0;
    int   acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rec_t r;
        if (rst && bus.valid_out) begin
            r.row = int'(bus.o_row);
            r.col = int'(bus.o_col);
            r.win = bus.o_window;
            r.fd  = bus.frame_done;
            r.cyc = cyc;
            got.push_back(r);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: tap (dr,dc) of centre (r,c) is pixel (r+dr-1, c+dc-1), zero outside the frame.
    function automatic win_t model_win(input int f, input int r, input int c);
        win_t w;
        int   rr;
        int   cc;
        w = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                rr = r + dr - 1;
                cc = c + dc - 1;
                if (rr >= 0 && rr < W && cc >= 0 && cc < W)
                    w[(3*dr+dc)*PIX_W +: PIX_W] = PIX_W'(img[f][rr*W+cc]);
            end
        end
        return w;
    endfunction

    function automatic win_t pack9(input int t[9]);
        win_t w;
        w = '0;
        for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = PIX_W'(t[k]);
        return w;
    endfunction

    task automatic set_frame(input int f, input int base, input bit rnd);
        for (int i = 0; i < W*W; i++)
            img[f][i] = rnd ? int'($urandom_range(1, 255)) : base + i + 1;
    endtask

    // Drives frame f in raster order; gap_pct sets the idle-beat rate. With
    // hold set, valid_in stays high with junk while in_ready is low.
    task automatic send_frame(input int f, input int gap_pct, input bit hold);
        int  stall;
        int  low;
        bit  done;
        for (int i = 0; i < W*W; i++) begin
            done  = 1'b0;
            stall = 0;
            while (!done) begin
                @(negedge clk);
                if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                    bus.valid_in = 1'b0;
                end else begin
                    bus.valid_in = 1'b1;
                    bus.i_data   = PIX_W'(img[f][i]);
                    if (bus.in_ready) begin
                        done    = 1'b1;
                        acc_cyc = cyc + 1;
                    end else begin
                        stall++;
                    end
                end
                if (stall > 3*W) begin
                    check($sformatf("f%0d_p%0d_in_ready_stall", f, i), bus.in_ready, 1);
                    bus.valid_in = 1'b0;
                    return;
                end
            end
        end
        if (hold) begin
            low = 0;
            for (int k = 0; k < 4*W; k++) begin
                @(negedge clk);
                if (!bus.in_ready) begin
                    low++;
                    bus.valid_in = 1'b1;
                    bus.i_data   = '1;
                end else begin
                    break;
                end
            end
            bus.valid_in = 1'b0;
            check("flush_in_ready_low_cycles", low, W + 1);
        end else begin
            @(negedge clk);
            bus.valid_in = 1'b0;
        end
    endtask

    task automatic wait_windows(input string tag, input int n);
        int t;
        t = 0;
        while (got.size() < n && t < 20*W*W) begin
            @(negedge clk);
            t++;
        end
        repeat (W + 3) @(negedge clk);
        check({tag, "_window_count"}, got.size(), n);
    endtask

    task automatic compare_frame(input string tag, input int f, input int off);
        for (int i = 0; i < W*W && off + i < got.size(); i++) begin
            check($sformatf("%s_w%0d_coord", tag, i), got[off+i].row * W + got[off+i].col, i);
            check($sformatf("%s_w%0d_window", tag, i), got[off+i].win, model_win(f, i / W, i % W));
            check($sformatf("%s_w%0d_frame_done", tag, i), got[off+i].fd, (i == W*W - 1));
        end
    endtask

    initial begin
        int acc0;
        bus.valid_in = 1'b0;
        bus.i_data   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid_out", bus.valid_out, 0);
        check("rst_o_window", bus.o_window, '0);
        check("rst_o_row", bus.o_row, 0);
        check("rst_o_col", bus.o_col, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst = 1'b1;

        // Two frames back-to-back, gap-free; first one holds valid_in through the flush
        set_frame(0, 0, 1'b0);
        set_frame(1, 100, 1'b0);
        got.delete();
        send_frame(0, 0, 1'b1);
        acc0 = acc_cyc;
        send_frame(1, 0, 1'b0);
        wait_windows("b2b", 2*W*W);
        compare_frame("b2b_f0", 0, 0);
        compare_frame("b2b_f1", 1, W*W);
        if (got.size() >= 2*W*W) begin
            check("plan_w00", got[0].win, pack9('{0, 0, 0, 0, 1, 2, 0, 5, 6}));
            check("plan_w11", got[5].win, pack9('{1, 2, 3, 5, 6, 7, 9, 10, 11}));
            check("plan_w33", got[15].win, pack9('{11, 12, 0, 15, 16, 0, 0, 0, 0}));
            check("plan_f1_w00", got[16].win, pack9('{0, 0, 0, 0, 101, 102, 0, 105, 106}));
            check("tail_latency", got[11].cyc - acc0, 1);
            check("flush_first_latency", got[12].cyc - acc0, 2);
            check("flush_back_to_back", got[15].cyc - got[12].cyc, W - 1);
            check("frame_done_latency", got[15].cyc - acc0, W + 1);
        end

        // Same image with ~50% idle beats
        got.delete();
        send_frame(0, 50, 1'b0);
        wait_windows("gappy", W*W);
        compare_frame("gappy", 0, 0);

        // Random pixel values with light gaps
        set_frame(0, 0, 1'b1);
        got.delete();
        send_frame(0, 30, 1'b0);
        wait_windows("rand", W*W);
        compare_frame("rand", 0, 0);

        // Reset pulsed while the last row is flushing
        set_frame(0, 0, 1'b0);
        got.delete();
        send_frame(0, 0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("midflush_rst_valid_out", bus.valid_out, 0);
        check("midflush_rst_in_ready", bus.in_ready, 1);
        check("midflush_rst_frame_done", bus.frame_done, 0);
        @(negedge clk);
        rst = 1'b1;
        got.delete();
        set_frame(0, 0, 1'b1);
        send_frame(0, 40, 1'b0);
        wait_windows("post_rst", W*W);
        compare_frame("post_rst", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
